// File: rtl/cpu_handshake_tx.sv
// -----------------------------------------------------------------------------
// cpu_handshake_tx
//
// Transmit side of a four-phase req/ack link towards a slow peripheral.
// The CPU pushes words into a small FIFO; a sender FSM pops one word at a time,
// presents it on `dados` and raises `send`, then walks the full four-phase
// sequence (send up, ack up, send down, ack down) before taking the next word.
// If the peripheral never acknowledges within TIMEOUT cycles the word is
// dropped, `err_timeout` is raised and the FSM parks in ERR until software
// clears it with `clr_err`.
//
// Parameters
//   DATA_W   width of a transferred word
//   DEPTH    FIFO entries (power of two, >= 2)
//   TIMEOUT  max cycles spent in SEND waiting for ack (>= 1)
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   wr_en        push request (ignored when full unless a pop happens the same cycle)
//   wr_data      word to push
//   clr_err      leaves ERR and clears err_timeout (only honoured in ERR)
//   ack          peripheral acknowledge, asynchronous to clk
//   dados        registered word under transfer
//   send         registered request to the peripheral
//   full/empty   registered FIFO status
//   level        FIFO occupancy, 0..DEPTH
//   estado       FSM state: 00 IDLE, 01 SEND, 10 WAIT_REL, 11 ERR
//   err_timeout  sticky timeout flag
// -----------------------------------------------------------------------------
module cpu_handshake_tx #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_err,
  input  logic                   ack,
  output logic [DATA_W-1:0]      dados,
  output logic                   send,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             estado,
  output logic                   err_timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SEND     = 2'b01,
    WAIT_REL = 2'b10,
    ERR      = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer. Only ack_s is allowed to reach the FSM.
  // ---------------------------------------------------------------------------
  logic ack_m;
  logic ack_s;

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_d;
  logic              push_ok;
  logic              pop;

  // A pop implies the FIFO is non-empty, so a push landing on a full FIFO in
  // the same cycle as a pop reuses the slot being freed.
  assign push_ok = wr_en && (!full || pop);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level;
    if (push_ok && !pop) begin
      level_d = level + LVL_W'(1);
    end else if (!push_ok && pop) begin
      level_d = level - LVL_W'(1);
    end
  end

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level_d;
      full  <= (level_d == LVL_W'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and level
  // already discards its contents, and an entry is only read after it has
  // been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sender FSM
  // ---------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             send_d;
  logic             err_d;

  // cnt_q holds the number of completed SEND cycles; cnt_inc is the count
  // including the current one, so the timeout fires in the TIMEOUT-th cycle
  // spent in SEND and send drops exactly TIMEOUT cycles after it rose.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // A still-high ack_s is left over from the previous transfer; wait for
      // it to fall so the new request is not acknowledged by a stale level.
      IDLE:     if (!empty && !ack_s) state_d = SEND;
      // ack wins a tie with the timeout.
      SEND:     if (ack_s)            state_d = WAIT_REL;
                else if (timeout_hit) state_d = ERR;
      WAIT_REL: if (!ack_s)           state_d = IDLE;
      ERR:      if (clr_err && !ack_s) state_d = IDLE;
    endcase
  end

  // Output logic: values to be registered at the coming edge
  always_comb begin
    pop    = 1'b0;
    send_d = 1'b0;
    err_d  = 1'b0;
    cnt_d  = '0;
    case (state_d)
      SEND:    send_d = 1'b1;
      ERR:     err_d  = 1'b1;
      default: ;
    endcase
    // Entering SEND takes the FIFO head; the counter restarts from zero.
    if (state_q == IDLE && state_d == SEND) begin
      pop = 1'b1;
    end
    if (state_q == SEND && state_d == SEND) begin
      cnt_d = cnt_inc;
    end
  end

  // Registered outputs and counter. dados only changes when a word is popped,
  // so it is stable from entry to SEND until the FSM leaves WAIT_REL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      send        <= 1'b0;
      err_timeout <= 1'b0;
      cnt_q       <= '0;
      dados       <= '0;
    end else begin
      send        <= send_d;
      err_timeout <= err_d;
      cnt_q       <= cnt_d;
      if (pop) begin
        dados <= mem[rd_ptr];
      end
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_cpu_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_cpu_handshake_tx
//
// Self-checking bench for cpu_handshake_tx. Words are pushed to a scoreboard
// queue when they are driven into the FIFO and popped when the DUT raises
// send, where dados is compared against them. A small peripheral model
// returns ack a programmable number of cycles after send; a second ack source
// lets individual scenarios place ack on an exact cycle.
// -----------------------------------------------------------------------------
module tb_cpu_handshake_tx;

  localparam int DATA_W  = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  localparam int S_IDLE = 0;
  localparam int S_SEND = 1;
  localparam int S_WREL = 2;
  localparam int S_ERR  = 3;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_err;
  logic              ack;
  logic [DATA_W-1:0] dados;
  logic              send;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic [1:0]        estado;
  logic              err_timeout;

  logic              ack_resp;
  logic              ack_man;
  logic              resp_en;
  int                resp_dly;

  int                n_chk;
  int                n_bad;
  logic [DATA_W-1:0] sb [$];

  assign ack = ack_resp | ack_man;

  cpu_handshake_tx #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_err    (clr_err),
    .ack        (ack),
    .dados      (dados),
    .send       (send),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .estado     (estado),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: raise ack resp_dly cycles after seeing send, drop it
  // once send has fallen.
  initial begin
    int dcnt;
    dcnt     = 0;
    ack_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        ack_resp = 1'b0;
        dcnt     = 0;
      end else if (ack_resp) begin
        if (!send) ack_resp = 1'b0;
      end else if (send) begin
        if (dcnt >= resp_dly - 1) begin
          ack_resp = 1'b1;
          dcnt     = 0;
        end else begin
          dcnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input bit accepted);
    wr_en   = 1'b1;
    wr_data = w;
    if (accepted) sb.push_back(w);
  endtask

  task automatic sb_check(input string tag);
    logic [DATA_W-1:0] exp_w;
    check({tag, " sb_has_word"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      exp_w = sb.pop_front();
      check({tag, " dados"}, 32'(dados), 32'(exp_w));
    end
  endtask

  // Wait for send, score the word, then follow the handshake back to IDLE.
  task automatic run_xfer(input string tag);
    int                n;
    logic [DATA_W-1:0] first;
    bit                stable;
    bit                saw_wait;
    n = 0;
    while (send !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " send_rise"}, 32'(send), 1);
    sb_check(tag);
    first    = dados;
    stable   = 1'b1;
    saw_wait = 1'b0;
    n        = 0;
    while ((estado == 2'(S_SEND) || estado == 2'(S_WREL)) && n < 100) begin
      if (dados !== first) stable = 1'b0;
      if (estado == 2'(S_WREL)) saw_wait = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, " dados_stable"}, 32'(stable), 1);
    check({tag, " saw_wait_rel"}, 32'(saw_wait), 1);
    check({tag, " back_idle"}, 32'(estado), S_IDLE);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (estado != 2'(S_IDLE) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(estado), S_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    clr_err  = 1'b0;
    ack_man  = 1'b0;
    resp_en  = 1'b0;
    resp_dly = 2;
    #1 rst = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst estado", 32'(estado), S_IDLE);
    check("rst send", 32'(send), 0);
    check("rst dados", 32'(dados), 0);
    check("rst level", 32'(level), 0);
    check("rst empty", 32'(empty), 1);
    check("rst full", 32'(full), 0);
    check("rst err", 32'(err_timeout), 0);

    // ---- single word, latency and four-phase sequence
    rst      = 1'b1;
    resp_en  = 1'b1;
    resp_dly = 2;
    push_word(4'hA, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("t1 level_after_push", 32'(level), 1);
    check("t1 empty_after_push", 32'(empty), 0);
    check("t1 send_not_yet", 32'(send), 0);
    check("t1 still_idle", 32'(estado), S_IDLE);
    @(negedge clk);
    check("t1 send_next_edge", 32'(send), 1);
    check("t1 estado_send", 32'(estado), S_SEND);
    run_xfer("t1");
    check("t1 level_end", 32'(level), 0);
    check("t1 empty_end", 32'(empty), 1);

    // ---- fill and overflow with ack held low
    resp_en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      push_word(DATA_W'(i), i <= 5);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("t2 level_full", 32'(level), DEPTH);
    check("t2 full", 32'(full), 1);
    check("t2 first_in_send", 32'(estado), S_SEND);
    check("t2 first_word", 32'(dados), 1);
    resp_en = 1'b1;
    for (int i = 0; i < 5; i++) run_xfer("t2");
    check("t2 level_end", 32'(level), 0);
    check("t2 empty_end", 32'(empty), 1);

    // ---- simultaneous push and pop while full
    resp_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_word(DATA_W'(8 + i), 1'b1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("t3 full_before", 32'(full), 1);
    resp_en = 1'b1;
    run_xfer("t3 head");
    check("t3 level_at_idle", 32'(level), DEPTH);
    push_word(4'hD, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("t3 level_push_pop", 32'(level), DEPTH);
    check("t3 full_push_pop", 32'(full), 1);
    check("t3 popped", 32'(estado), S_SEND);
    for (int i = 0; i < 5; i++) run_xfer("t3");
    check("t3 level_end", 32'(level), 0);

    // ---- timeout, push while in ERR, clear
    resp_en = 1'b0;
    push_word(4'h3, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("t4 send_rise", 32'(send), 1);
    sb_check("t4");
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t4 send_last_cycle", 32'(send), 1);
    check("t4 estado_last_cycle", 32'(estado), S_SEND);
    @(negedge clk);
    check("t4 send_drop", 32'(send), 0);
    check("t4 err_set", 32'(err_timeout), 1);
    check("t4 estado_err", 32'(estado), S_ERR);
    push_word(4'h7, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("t4 push_in_err", 32'(level), 1);
    check("t4 stay_err", 32'(estado), S_ERR);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t4 clr_estado", 32'(estado), S_IDLE);
    check("t4 clr_err", 32'(err_timeout), 0);
    resp_en = 1'b1;
    run_xfer("t4 after_clr");

    // ---- ack arrives in the cycle the counter reaches TIMEOUT
    resp_en = 1'b0;
    push_word(4'h5, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("t5 send_rise", 32'(send), 1);
    sb_check("t5");
    clr_err = 1'b1;
    repeat (TIMEOUT - 3) @(negedge clk);
    ack_man = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 still_send", 32'(estado), S_SEND);
    @(negedge clk);
    check("t5 ack_wins", 32'(estado), S_WREL);
    check("t5 no_err", 32'(err_timeout), 0);
    check("t5 send_drop", 32'(send), 0);
    ack_man = 1'b0;
    clr_err = 1'b0;
    wait_idle("t5");

    // ---- reset in the middle of a transfer
    resp_en = 1'b0;
    push_word(4'h6, 1'b1);
    @(negedge clk);
    push_word(4'hE, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("t6 in_send", 32'(estado), S_SEND);
    check("t6 level", 32'(level), 1);
    sb_check("t6");
    #2 rst = 1'b0;
    #1;
    check("t6 rst_send", 32'(send), 0);
    check("t6 rst_level", 32'(level), 0);
    check("t6 rst_estado", 32'(estado), S_IDLE);
    check("t6 rst_empty", 32'(empty), 1);
    check("t6 rst_dados", 32'(dados), 0);
    sb.delete();
    @(negedge clk);
    rst     = 1'b1;
    resp_en = 1'b1;
    push_word(4'hB, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    run_xfer("t6 resume");
    check("t6 level_end", 32'(level), 0);
    check("sb drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_handshake_tx.md
CPU_HANDSHAKE_TX -- requirements
Module: cpu_handshake_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, width of the transferred data word.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of entries in the transmit FIFO; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the maximum number of cycles spent in SEND waiting for ack; it is at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port wr_en, input, 1 bit: push request into the FIFO.
REQ-007 The block SHALL have port wr_data, input, DATA_W bits: word to push.
REQ-008 The block SHALL have port clr_err, input, 1 bit: clears the ERR state and err_timeout.
REQ-009 The block SHALL have port ack, input, 1 bit: peripheral acknowledge, asynchronous to clk.
REQ-010 The block SHALL have port dados, output, DATA_W bits: the registered word under transfer.
REQ-011 The block SHALL have port send, output, 1 bit: registered request to the peripheral.
REQ-012 The block SHALL have port full, output, 1 bit, and port empty, output, 1 bit: FIFO status, registered.
REQ-013 The block SHALL have port level, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-014 The block SHALL have port estado, output, 2 bits: current FSM state encoding.
REQ-015 The block SHALL have port err_timeout, output, 1 bit: sticky timeout flag.

Function
REQ-016 ack SHALL pass through a two-flop synchronizer (ack_s); the FSM SHALL use only ack_s.
REQ-017 The FIFO SHALL accept a push when wr_en=1 and full=0; when full=1 and no pop occurs in the same cycle, the push SHALL be ignored and the contents left unchanged.
REQ-018 A simultaneous push and pop SHALL both take effect, leave level unchanged and be allowed even when full=1.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; full SHALL equal (level==DEPTH) and empty SHALL equal (level==0).
REQ-020 The FSM SHALL have states IDLE=00, SEND=01, WAIT_REL=10 and ERR=11, and estado SHALL reflect the current state.
REQ-021 In IDLE with empty=0 and ack_s=0, the block SHALL on the next edge load dados from the FIFO head, pop that word, set send=1 and enter SEND.
REQ-022 In IDLE with empty=0 and ack_s=1 (stale ack), the block SHALL stay in IDLE.
REQ-023 A word written at edge N into an empty FIFO, with the FSM in IDLE, SHALL produce send=1 after edge N+1.
REQ-024 In SEND with ack_s=1, the block SHALL set send=0 and enter WAIT_REL.
REQ-025 In WAIT_REL with ack_s=0, the block SHALL enter IDLE; a transfer SHALL complete in the full four-phase sequence send up, ack up, send down, ack down.
REQ-026 dados SHALL remain stable from the entry to SEND until the exit from WAIT_REL.
REQ-027 A cycle counter SHALL reset on entry to SEND and increment each cycle in SEND.
REQ-028 If the counter reaches TIMEOUT with ack_s=0, the block SHALL set send=0 and err_timeout=1, enter ERR, and drop the word.
REQ-029 If ack_s=1 in the same cycle the counter reaches TIMEOUT, ack SHALL win and the block SHALL enter WAIT_REL.
REQ-030 In ERR with clr_err=1 and ack_s=0, the block SHALL clear err_timeout and enter IDLE; otherwise it SHALL stay in ERR.
REQ-031 The FIFO SHALL continue to accept pushes while the FSM is in ERR.
REQ-032 clr_err SHALL be ignored in all states other than ERR.

Reset
REQ-033 When rst=0, the block SHALL immediately set state to IDLE, send=0, dados=0, err_timeout=0, level=0, empty=1, full=0, clear the pointers, counter and synchronizer, and discard all FIFO contents.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer without completing the handshake; after release the block SHALL resume from IDLE.

Verification
REQ-035 Single word: after reset release, push 4'hA with a responder that returns ack 2 cycles after send -> dados=A, send high, estado goes 01 then 10 then 00, level returns to 0.
REQ-036 Fill and overflow: with ack held 0, push 6 words (1..6) into DEPTH=4 -> word 1 goes out, full=1 after words 2-5 are pushed, word 6 is ignored, and later transfers carry 1, 2, 3, 4, 5 in order.
REQ-037 Timeout: push 4'h3 with no ack -> TIMEOUT cycles after send rises, send=0, err_timeout=1, estado=11; pulse clr_err -> estado=00, err_timeout=0.
REQ-038 Push and pop at full: with full=1 and a pop in progress, push a word -> level stays at 4 and the word is transferred last.
REQ-039 Reset mid-transfer: assert rst=0 while estado=01 -> send=0, level=0 and estado=00 with no clock edge required.
REQ-040 Ack race: assert ack_s in the same cycle the counter reaches TIMEOUT -> estado=10 and err_timeout stays 0.
